// File: rtl/t08_mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-port signals around the arbiter.
// Handshake: a requester raises its request (i_req, or d_read/d_write) with
// address/data valid and holds all of them unchanged until it sees its
// one-cycle ack, then drops the request on the edge that ends the ack cycle.
// On the memory side a strobe stays high until mem_busy is sampled low;
// mem_rdata is valid in that cycle.
interface t08_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_sel;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              bus_err;
  logic              stall;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_sel;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_busy;

  // Arbiter side.
  modport slave (
    input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_sel,
    input  mem_rdata, mem_busy,
    output i_ack, i_rdata, d_ack, d_rdata, bus_err, stall,
    output mem_read, mem_write, mem_addr, mem_wdata, mem_sel
  );

  // Requester / memory-model side.
  modport master (
    output i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_sel,
    output mem_rdata, mem_busy,
    input  i_ack, i_rdata, d_ack, d_rdata, bus_err, stall,
    input  mem_read, mem_write, mem_addr, mem_wdata, mem_sel
  );
endinterface

// File: rtl/t08_mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter for a single memory port.
// One transaction at a time, round-robin under contention, registered
// strobes/acks, and a WAIT timeout that completes the transaction with
// bus_err instead of hanging the CPU.
module t08_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  t08_mem_arbiter_if.slave     bus,
  output logic [1:0]           dbg_state
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic {G_INSTR, G_DATA} grant_t;

  state_t            state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  grant_t            grant_q, grant_d;
  logic              wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_sel_q, mem_sel_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              bus_err_q, bus_err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_pend, d_pend, pick_data;

  assign i_pend  = bus.i_req;
  assign d_pend  = bus.d_read | bus.d_write;
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and next-output logic; bus_err_d doubles as the error flag,
  // since it is only ever set on the transition into DONE.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    wr_d         = wr_q;
    cnt_d        = cnt_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_sel_d    = mem_sel_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    bus_err_d    = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    pick_data    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Under contention the side that did not win last time goes next.
        pick_data = d_pend & (~i_pend | (last_grant_q == G_INSTR));
        if (i_pend | d_pend) begin
          state_d = S_ISSUE;
          if (pick_data) begin
            grant_d      = G_DATA;
            last_grant_d = G_DATA;
            wr_d         = bus.d_write;
            mem_read_d   = ~bus.d_write;
            mem_write_d  = bus.d_write;
            mem_addr_d   = bus.d_addr;
            mem_wdata_d  = bus.d_wdata;
            mem_sel_d    = bus.d_sel;
          end else begin
            grant_d      = G_INSTR;
            last_grant_d = G_INSTR;
            wr_d         = 1'b0;
            mem_read_d   = 1'b1;
            mem_write_d  = 1'b0;
            mem_addr_d   = bus.i_addr;
            mem_wdata_d  = '0;
            mem_sel_d    = 4'hF;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (!bus.mem_busy) begin
          state_d     = S_DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          i_ack_d     = (grant_q == G_INSTR);
          d_ack_d     = (grant_q == G_DATA);
          if (!wr_q) begin
            if (grant_q == G_DATA) d_rdata_d = bus.mem_rdata;
            else                   i_rdata_d = bus.mem_rdata;
          end
        end else if (cnt_inc == TO_VAL) begin
          state_d     = S_DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          bus_err_d   = 1'b1;
          i_ack_d     = (grant_q == G_INSTR);
          d_ack_d     = (grant_q == G_DATA);
          if (!wr_q) begin
            if (grant_q == G_DATA) d_rdata_d = '0;
            else                   i_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered-output update; reset aborts any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= G_INSTR;
      grant_q      <= G_INSTR;
      wr_q         <= 1'b0;
      cnt_q        <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_sel_q    <= 4'h0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      bus_err_q    <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      wr_q         <= wr_d;
      cnt_q        <= cnt_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_sel_q    <= mem_sel_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      bus_err_q    <= bus_err_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_sel   = mem_sel_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  // Only unregistered output: the CPU must stall in the same cycle it asks.
  assign bus.stall     = (bus.i_req | bus.d_read | bus.d_write) & ~(i_ack_q | d_ack_q);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_t08_mem_arbiter.sv
// Directed bench for t08_mem_arbiter: a per-cycle vector table for single
// transactions, then hand-written contention, timeout and reset sequences.
module tb_t08_mem_arbiter;

  localparam logic [31:0] IR = 32'h0051_0093;
  localparam logic [31:0] IA = 32'h0000_0010;
  localparam logic [31:0] DA = 32'h0000_2000;
  localparam logic [31:0] WD = 32'hDEAD_BEEF;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  t08_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  t08_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.i_req = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    bus.i_addr = IA; bus.d_addr = DA; bus.d_wdata = WD; bus.d_sel = 4'b0011;
    bus.mem_busy = 1'b0; bus.mem_rdata = IR;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Run until an ack (or the bound); checks exclusivity and stall each cycle.
  task automatic wait_ack(input int bound, output int cycles, output int strobes, output logic got);
    cycles = 0; strobes = 0; got = 1'b0;
    while (!got && cycles < bound) begin
      tick();
      cycles++;
      if (bus.mem_read | bus.mem_write) strobes++;
      check("ack_overlap", bus.i_ack & bus.d_ack, 0);
      check("strobe_onehot", bus.mem_read & bus.mem_write, 0);
      if (bus.i_ack | bus.d_ack) got = 1'b1;
      else check("stall_pending", bus.stall, 1);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  in;    // {i_req, d_read, d_write, mem_busy}
    logic [5:0]  ex;    // {mem_read, mem_write, i_ack, d_ack, bus_err, stall}
    logic [1:0]  st;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic [31:0] irdata, drdata;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] in, input logic [5:0] ex, input logic [1:0] st,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] sel,
                              input logic [31:0] irdata, input logic [31:0] drdata);
    vec_t v;
    v.in = in; v.ex = ex; v.st = st; v.addr = addr; v.wdata = wdata;
    v.sel = sel; v.irdata = irdata; v.drdata = drdata;
    return v;
  endfunction

  vec_t vecs [15];

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q [$];   // {expect_data_grant, expected read data}

  initial begin
    int cyc, stb;
    logic got;
    logic [32:0] e;
    logic [5:0] act_ex;

    // Fetch read, data write with 4 busy cycles, read+write treated as write.
    vecs[0]  = mk(4'b1000, 6'b100001, 2'd1, IA, 32'h0, 4'hF, 32'h0, 32'h0);
    vecs[1]  = mk(4'b1000, 6'b100001, 2'd2, IA, 32'h0, 4'hF, 32'h0, 32'h0);
    vecs[2]  = mk(4'b1000, 6'b001000, 2'd3, IA, 32'h0, 4'hF, IR,    32'h0);
    vecs[3]  = mk(4'b0000, 6'b000000, 2'd0, IA, 32'h0, 4'hF, IR,    32'h0);
    vecs[4]  = mk(4'b0010, 6'b010001, 2'd1, DA, WD,    4'h3, IR,    32'h0);
    vecs[5]  = mk(4'b0011, 6'b010001, 2'd2, DA, WD,    4'h3, IR,    32'h0);
    vecs[6]  = mk(4'b0011, 6'b010001, 2'd2, DA, WD,    4'h3, IR,    32'h0);
    vecs[7]  = mk(4'b0011, 6'b010001, 2'd2, DA, WD,    4'h3, IR,    32'h0);
    vecs[8]  = mk(4'b0011, 6'b010001, 2'd2, DA, WD,    4'h3, IR,    32'h0);
    vecs[9]  = mk(4'b0010, 6'b000100, 2'd3, DA, WD,    4'h3, IR,    32'h0);
    vecs[10] = mk(4'b0000, 6'b000000, 2'd0, DA, WD,    4'h3, IR,    32'h0);
    vecs[11] = mk(4'b0110, 6'b010001, 2'd1, DA, WD,    4'h3, IR,    32'h0);
    vecs[12] = mk(4'b0110, 6'b010001, 2'd2, DA, WD,    4'h3, IR,    32'h0);
    vecs[13] = mk(4'b0110, 6'b000100, 2'd3, DA, WD,    4'h3, IR,    32'h0);
    vecs[14] = mk(4'b0000, 6'b000000, 2'd0, DA, WD,    4'h3, IR,    32'h0);

    clear_inputs();
    do_reset();

    // Reset state.
    check("rst_state", dbg_state, 0);
    check("rst_strobes", {bus.mem_read, bus.mem_write}, 0);
    check("rst_acks_err", {bus.i_ack, bus.d_ack, bus.bus_err}, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_mem_sel", bus.mem_sel, 0);
    check("rst_rdata", bus.i_rdata | bus.d_rdata, 0);
    check("rst_stall", bus.stall, 0);

    // Table-driven single transactions.
    for (int i = 0; i < 15; i++) begin
      {bus.i_req, bus.d_read, bus.d_write, bus.mem_busy} = vecs[i].in;
      tick();
      act_ex = {bus.mem_read, bus.mem_write, bus.i_ack, bus.d_ack, bus.bus_err, bus.stall};
      check($sformatf("v%0d_ctl{rd,wr,iack,dack,err,stall}", i), act_ex, vecs[i].ex);
      check($sformatf("v%0d_state", i), dbg_state, vecs[i].st);
      check($sformatf("v%0d_mem_addr", i), bus.mem_addr, vecs[i].addr);
      check($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, vecs[i].wdata);
      check($sformatf("v%0d_mem_sel", i), bus.mem_sel, vecs[i].sel);
      check($sformatf("v%0d_i_rdata", i), bus.i_rdata, vecs[i].irdata);
      check($sformatf("v%0d_d_rdata", i), bus.d_rdata, vecs[i].drdata);
    end

    // Contention from reset: DATA, INSTR, DATA, INSTR.
    do_reset();
    bus.i_addr = 32'h100; bus.d_addr = 32'h200;
    exp_q.push_back({1'b1, 32'hC0DE_0000});
    exp_q.push_back({1'b0, 32'hC0DE_0001});
    exp_q.push_back({1'b1, 32'hC0DE_0002});
    exp_q.push_back({1'b0, 32'hC0DE_0003});
    bus.mem_rdata = 32'hC0DE_0000;
    bus.i_req = 1'b1; bus.d_read = 1'b1;
    for (int t = 0; t < 4; t++) begin
      wait_ack(20, cyc, stb, got);
      check($sformatf("rr%0d_ack_seen", t), got, 1);
      check($sformatf("rr%0d_latency", t), cyc, 3);
      if (got && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("rr%0d_d_ack", t), bus.d_ack, e[32]);
        check($sformatf("rr%0d_i_ack", t), bus.i_ack, !e[32]);
        check($sformatf("rr%0d_rdata", t), e[32] ? bus.d_rdata : bus.i_rdata, e[31:0]);
        check($sformatf("rr%0d_stall_at_ack", t), bus.stall, 0);
        if (bus.d_ack) bus.d_read = 1'b0; else bus.i_req = 1'b0;
      end
      bus.mem_rdata = 32'hC0DE_0001 + 32'(t);
      tick();
      check($sformatf("rr%0d_idle_no_ack", t), {bus.i_ack, bus.d_ack}, 0);
      if (t < 3) begin
        bus.i_req = 1'b1; bus.d_read = 1'b1;
      end else begin
        bus.i_req = 1'b0; bus.d_read = 1'b0;
      end
    end
    check("rr_queue_empty", exp_q.size(), 0);

    // Timeout: mem_busy stuck high on a data read.
    bus.d_read = 1'b1; bus.mem_busy = 1'b1; bus.mem_rdata = 32'h1234_5678;
    wait_ack(400, cyc, stb, got);
    check("to_ack_seen", got, 1);
    check("to_strobe_cycles", stb, 256);
    check("to_ack_err", {bus.i_ack, bus.d_ack, bus.bus_err}, 3'b011);
    check("to_d_rdata_zero", bus.d_rdata, 0);
    bus.d_read = 1'b0; bus.mem_busy = 1'b0;
    tick();
    check("to_err_pulse_end", {bus.d_ack, bus.bus_err}, 0);
    bus.d_read = 1'b1; bus.mem_rdata = 32'h0BAD_F00D;
    wait_ack(20, cyc, stb, got);
    check("to_next_latency", cyc, 3);
    check("to_next_ack_err", {bus.d_ack, bus.bus_err}, 2'b10);
    check("to_next_rdata", bus.d_rdata, 32'h0BAD_F00D);
    bus.d_read = 1'b0;
    tick();

    // Reset during WAIT of a data read.
    bus.d_read = 1'b1; bus.mem_busy = 1'b1; bus.d_addr = 32'h300;
    tick();
    tick();
    tick();
    check("rw_in_wait", dbg_state, 2);
    check("rw_read_high", bus.mem_read, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.mem_busy = 1'b0; bus.mem_rdata = 32'h55AA_55AA;
    check("rw_strobes_low", {bus.mem_read, bus.mem_write}, 0);
    check("rw_state_idle", dbg_state, 0);
    check("rw_no_ack", {bus.i_ack, bus.d_ack, bus.bus_err}, 0);
    check("rw_rdata_cleared", bus.d_rdata, 0);
    wait_ack(20, cyc, stb, got);
    check("rw_after_latency", cyc, 3);
    check("rw_after_d_ack", bus.d_ack, 1);
    check("rw_after_addr", bus.mem_addr, 32'h300);
    check("rw_after_rdata", bus.d_rdata, 32'h55AA_55AA);
    bus.d_read = 1'b0;
    tick();

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
